// File: rtl/simd_mac_seq.sv
// simd_mac_seq: job sequencer that clears the MAC array, gates LEN operand rows into it and drains the lane results as beats
module simd_mac_seq #(
    parameter int MAC_BW    = 8,
    parameter int LANES     = 64,
    parameter int OUT_LANES = 8,
    parameter int LEN_W     = 16,
    parameter int MAC_LAT   = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [LEN_W-1:0]                cmd_len,
    input  logic [1:0]                      cmd_mode,
    input  logic                            op_valid,
    output logic                            op_ready,
    output logic [1:0]                      arr_mode,
    output logic                            arr_clr,
    output logic                            arr_en,
    input  logic [LANES*2*MAC_BW-1:0]       arr_res,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [OUT_LANES*2*MAC_BW-1:0]   res_data,
    output logic                            res_last,
    output logic                            busy
);
    localparam int BEATS = LANES / OUT_LANES;
    localparam int RW    = 2 * MAC_BW;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int WW    = MAC_LAT > 1 ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, ACC, WAIT, DRAIN} state_t;

    state_t                             state_q, state_d;
    logic [LEN_W-1:0]                   len_q, len_d;
    logic [LEN_W-1:0]                   step_q, step_d;
    logic [1:0]                         mode_q, mode_d;
    logic [WW-1:0]                      wait_q, wait_d;
    logic [BW-1:0]                      beat_q, beat_d;
    logic [BEATS-1:0][OUT_LANES*RW-1:0] snap_q, snap_d;

    // state, job parameters, counters and result snapshot; reset abandons any job in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            step_q  <= '0;
            mode_q  <= '0;
            wait_q  <= '0;
            beat_q  <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            snap_q  <= snap_d;
        end
    end

    // job sequencing: accept, clear, accumulate exactly len rows, let the pipeline settle, drain
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        step_d  = step_q;
        mode_d  = mode_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        snap_d  = snap_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    len_d   = cmd_len;
                    mode_d  = cmd_mode;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                step_d  = '0;
                wait_d  = '0;
                state_d = (len_q != '0) ? ACC : WAIT;
            end
            ACC: begin
                if (op_valid) begin
                    step_d  = step_q + LEN_W'(1);
                    state_d = (step_q == len_q - LEN_W'(1)) ? WAIT : ACC;
                end
            end
            WAIT: begin
                if (wait_q == WW'(MAC_LAT - 1)) begin
                    snap_d  = arr_res;
                    beat_d  = '0;
                    state_d = DRAIN;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            DRAIN: begin
                if (res_ready) begin
                    beat_d  = beat_q + BW'(1);
                    state_d = (beat_q == BW'(BEATS - 1)) ? IDLE : DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign arr_clr   = state_q == CLEAR;
    assign op_ready  = state_q == ACC;
    assign arr_en    = op_valid & op_ready;
    assign arr_mode  = mode_q;
    assign res_valid = state_q == DRAIN;
    assign res_last  = res_valid && (beat_q == BW'(BEATS - 1));
    assign res_data  = res_valid ? snap_q[beat_q] : '0;
endmodule
